// File: rtl/gcn_memory_loader.sv
// Write-side loader for the GCN scratch memory: places a valid/ready word stream
// at weight addresses 0..WEIGHT_COLS-1, then at feature addresses FEATURE_BASE+row.
module gcn_memory_loader #(
  parameter int               FEATURE_ROWS          = 6,
  parameter int               WEIGHT_COLS           = 3,
  parameter int               DATA_WIDTH            = 16,
  parameter logic [12:0]      FEATURE_BASE          = 13'h200,
  parameter int               COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int               COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             in_ready,
  output logic                             write_enable,
  output logic [12:0]                      write_address,
  output logic [DATA_WIDTH-1:0]            write_data,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
  output logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
  output logic                             busy,
  output logic                             load_done
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LOAD_WEIGHT  = 2'd1,
    LOAD_FEATURE = 2'd2,
    DONE         = 2'd3
  } state_t;

  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  WEIGHT_LAST  = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);
  localparam logic [COUNTER_FEATURE_WIDTH-1:0] FEATURE_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

  state_t                           state_r;
  logic                             write_enable_r;
  logic [12:0]                      write_address_r;
  logic [DATA_WIDTH-1:0]            write_data_r;
  logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count_r;
  logic [COUNTER_FEATURE_WIDTH-1:0] feature_count_r;
  logic                             busy_r;
  logic                             load_done_r;

  logic                             ready_s;
  logic                             transfer_s;
  logic [12:0]                      target_address_s;

  // Ready is decoded straight from state so the upstream sees it in the same cycle.
  always_comb begin
    ready_s          = 1'b0;
    target_address_s = 13'd0;
    if ((state_r == LOAD_WEIGHT) || (state_r == LOAD_FEATURE)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if (state_r == LOAD_WEIGHT) begin
      target_address_s = 13'(weight_count_r);
    end else begin
      target_address_s = FEATURE_BASE + 13'(feature_count_r);
    end
  end

  assign transfer_s = in_valid && ready_s;

  // Load sequencer and registered memory write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      write_enable_r  <= 1'b0;
      write_address_r <= 13'd0;
      write_data_r    <= '0;
      weight_count_r  <= '0;
      feature_count_r <= '0;
      busy_r          <= 1'b0;
      load_done_r     <= 1'b0;
    end else begin
      write_enable_r <= transfer_s;
      if (transfer_s) begin
        write_address_r <= target_address_s;
        write_data_r    <= in_data;
      end

      case (state_r)
        IDLE, DONE: begin
          // start is only honoured outside an active load
          if (start) begin
            state_r         <= LOAD_WEIGHT;
            weight_count_r  <= '0;
            feature_count_r <= '0;
            busy_r          <= 1'b1;
            load_done_r     <= 1'b0;
          end
        end
        LOAD_WEIGHT: begin
          if (transfer_s) begin
            if (weight_count_r == WEIGHT_LAST) begin
              state_r         <= LOAD_FEATURE;
              feature_count_r <= '0;
            end else begin
              weight_count_r <= weight_count_r + COUNTER_WEIGHT_WIDTH'(1);
            end
          end
        end
        LOAD_FEATURE: begin
          if (transfer_s) begin
            if (feature_count_r == FEATURE_LAST) begin
              state_r     <= DONE;
              busy_r      <= 1'b0;
              load_done_r <= 1'b1;
            end else begin
              feature_count_r <= feature_count_r + COUNTER_FEATURE_WIDTH'(1);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          load_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = ready_s;
  assign write_enable  = write_enable_r;
  assign write_address = write_address_r;
  assign write_data    = write_data_r;
  assign weight_count  = weight_count_r;
  assign feature_count = feature_count_r;
  assign busy          = busy_r;
  assign load_done     = load_done_r;

endmodule

// File: tb/tb_gcn_memory_loader.sv
// Scoreboard bench for gcn_memory_loader: expected writes are queued as words are
// scheduled and checked against the memory write port as writes appear.
module tb_gcn_memory_loader;

  localparam int          DW    = 16;
  localparam int          NW    = 3;
  localparam int          NF    = 6;
  localparam logic [12:0] FBASE = 13'h200;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          write_enable;
  logic [12:0]   write_address;
  logic [DW-1:0] write_data;
  logic [1:0]    weight_count;
  logic [2:0]    feature_count;
  logic          busy;
  logic          load_done;

  gcn_memory_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .weight_count  (weight_count),
    .feature_count (feature_count),
    .busy          (busy),
    .load_done     (load_done)
  );

  typedef struct {
    logic [12:0]   addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   we_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue expected writes for stream word indices first..last (word k carries k+1).
  task automatic push_range(input int first, input int last);
    exp_t e;
    for (int k = first; k <= last; k++) begin
      e.addr = (k < NW) ? 13'(k) : FBASE + 13'(k - NW);
      e.data = DW'(k + 1);
      e.done = (k == NW + NF - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && write_enable) begin
      we_count++;
      check_eq("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("wr_addr", 32'(write_address), 32'(e.addr));
        check_eq("wr_data", 32'(write_data), 32'(e.data));
        check_eq("wr_done", 32'(load_done), 32'(e.done));
      end
    end
  end

  // Entered and left at a negedge; waits (bounded) for ready, then lets one edge transfer.
  task automatic send_word(input logic [DW-1:0] d, input bit bubble);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (bubble) begin
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("bubble_we", 32'(write_enable), 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_we"}, 32'(write_enable), 32'd0);
    check_eq({tag, "_addr"}, 32'(write_address), 32'd0);
    check_eq({tag, "_data"}, 32'(write_data), 32'd0);
    check_eq({tag, "_wcnt"}, 32'(weight_count), 32'd0);
    check_eq({tag, "_fcnt"}, 32'(feature_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(load_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_cnt;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");

    // idle with a valid word but no start: nothing may be consumed
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    repeat (4) begin
      @(negedge clk);
      check_eq("idle_ready", 32'(in_ready), 32'd0);
      check_eq("idle_we", 32'(write_enable), 32'd0);
    end
    in_valid = 1'b0;

    // full back-to-back load
    pulse_start();
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_wcnt", 32'(weight_count), 32'd0);
    base_cnt = we_count;
    push_range(0, NW + NF - 1);
    for (int k = 0; k < NW + NF; k++) send_word(DW'(k + 1), 1'b0);
    in_valid = 1'b0;
    check_eq("full_done", 32'(load_done), 32'd1);
    check_eq("full_last_we", 32'(write_enable), 32'd1);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    check_eq("full_busy", 32'(busy), 32'd0);
    check_eq("full_wcnt", 32'(weight_count), 32'(NW - 1));
    check_eq("full_fcnt", 32'(feature_count), 32'(NF - 1));
    @(negedge clk);
    check_eq("full_we_count", 32'(we_count - base_cnt), 32'(NW + NF));
    check_eq("full_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("done_hold", 32'(load_done), 32'd1);

    // restart from DONE, then a bubbled stream
    pulse_start();
    check_eq("restart_done", 32'(load_done), 32'd0);
    check_eq("restart_wcnt", 32'(weight_count), 32'd0);
    check_eq("restart_busy", 32'(busy), 32'd1);
    push_range(0, NW + NF - 1);
    for (int k = 0; k < NW + NF; k++) send_word(DW'(k + 1), 1'b1);
    check_eq("bubble_done", 32'(load_done), 32'd1);
    check_eq("bubble_sb_empty", 32'(sb.size()), 32'd0);

    // start while busy is ignored; start on the final transfer is ignored too
    pulse_start();
    push_range(0, NW + NF - 1);
    for (int k = 0; k < 4; k++) send_word(DW'(k + 1), 1'b0);
    in_valid = 1'b0;
    pulse_start();
    check_eq("busy_start_wcnt", 32'(weight_count), 32'(NW - 1));
    check_eq("busy_start_fcnt", 32'(feature_count), 32'd1);
    check_eq("busy_start_busy", 32'(busy), 32'd1);
    for (int k = 4; k < NW + NF - 1; k++) send_word(DW'(k + 1), 1'b0);
    start = 1'b1;
    send_word(DW'(NW + NF), 1'b0);
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq("coinc_done", 32'(load_done), 32'd1);
    @(negedge clk);
    check_eq("coinc_done_hold", 32'(load_done), 32'd1);
    check_eq("coinc_busy", 32'(busy), 32'd0);
    check_eq("coinc_wcnt", 32'(weight_count), 32'(NW - 1));
    check_eq("coinc_sb_empty", 32'(sb.size()), 32'd0);

    // reset mid-load while the 5th write strobe is on the port
    pulse_start();
    push_range(0, 4);
    for (int k = 0; k < 5; k++) send_word(DW'(k + 1), 1'b0);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("midrst");
    check_eq("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    push_range(0, NW + NF - 1);
    for (int k = 0; k < NW + NF; k++) send_word(DW'(k + 1), 1'b0);
    in_valid = 1'b0;
    check_eq("reload_done", 32'(load_done), 32'd1);
    @(negedge clk);
    check_eq("reload_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gcn_memory_loader.md
Name: gcn_memory_loader

Overview:
- Write-side loader for the GCN weight/feature scratch memory.
- Accepts a valid/ready word stream and writes it into the memory address map that the read-address counter later walks.
- Weight columns go to addresses 0..WEIGHT_COLS-1. Feature rows go to FEATURE_BASE + row.
- Sits between the host/DMA stream and the memory write port. Signals completion so the compute FSM can start reading.

Parameters:
FEATURE_ROWS, 6, number of feature rows to load
WEIGHT_COLS, 3, number of weight columns to load
DATA_WIDTH, 16, width of one stream word / memory word
FEATURE_BASE, 13'h200, write address of feature row 0
COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), weight counter width
COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), feature counter width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse: begin a load sequence
in_valid  input  1  stream word valid
in_data  input  DATA_WIDTH  stream word
in_ready  output  1  loader can accept a word this cycle
write_enable  output  1  memory write strobe (registered)
write_address  output  13  memory write address (registered)
write_data  output  DATA_WIDTH  memory write data (registered)
weight_count  output  COUNTER_WEIGHT_WIDTH  weight columns written so far, current index
feature_count  output  COUNTER_FEATURE_WIDTH  feature rows written so far, current index
busy  output  1  high in LOAD_WEIGHT or LOAD_FEATURE
load_done  output  1  high in DONE state

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (reset_n).
- Reset values: state=IDLE, in_ready=0, write_enable=0, write_address=0, write_data=0, weight_count=0, feature_count=0, busy=0, load_done=0.
- States: IDLE, LOAD_WEIGHT, LOAD_FEATURE, DONE.
- IDLE -> LOAD_WEIGHT on start. Both counters clear to 0 on that edge.
- Handshake:
  - in_ready = 1 combinationally in LOAD_WEIGHT and LOAD_FEATURE, 0 otherwise.
  - A transfer occurs on a clock edge where in_valid && in_ready.
  - in_valid may drop between words. No transfer means no write.
- Write latency is one cycle. On a transfer edge the write registers are loaded as follows, and hold for exactly that following cycle:
  - write_enable <= 1
  - write_data <= in_data
  - write_address <= weight_count (LOAD_WEIGHT) or FEATURE_BASE + feature_count (LOAD_FEATURE)
- write_enable <= 0 on every non-transfer edge. write_address and write_data hold their last value.
- Arithmetic: write_address is 13 bits. The feature address is the zero-extended feature_count added to FEATURE_BASE, with no wrap checking.
- LOAD_WEIGHT:
  - On a transfer with weight_count < WEIGHT_COLS-1: weight_count increments.
  - On a transfer with weight_count == WEIGHT_COLS-1: weight_count holds at WEIGHT_COLS-1, feature_count <= 0, go to LOAD_FEATURE.
- LOAD_FEATURE:
  - On a transfer with feature_count < FEATURE_ROWS-1: feature_count increments.
  - On the transfer at FEATURE_ROWS-1: count holds, go to DONE.
- DONE:
  - load_done = 1, in_ready = 0. Counters hold their final values.
  - start -> LOAD_WEIGHT (counters clear, load_done drops on the same edge).
- start while busy is ignored. No restart and no counter change.
- start coincident with the final feature transfer: the transfer completes, the FSM enters DONE, and start is ignored.
- The final write (last feature) appears on write_enable in the same cycle load_done first goes high.
- reset_n asserted mid-load: all state clears immediately. Any in-flight write_enable drops asynchronously. Partial memory contents are not undone.
- Words presented while in_ready=0 are not consumed. The upstream must hold them.

Test Plan:
- Reset then idle: reset_n=0 -> all outputs 0. Release, in_valid=1 with no start -> in_ready=0, no writes.
- Full back-to-back load (defaults): start, then 9 words 0x0001..0x0009 with in_valid constant.
  - Required writes: (0,0x0001), (1,0x0002), (2,0x0003), (0x200,0x0004) ... (0x205,0x0009).
  - load_done rises with the 0x205 write.
  - Exactly 9 write_enable cycles.
- Bubbled stream: same data with in_valid toggling 1,0,1,0 -> identical address/data sequence, and write_enable=0 in bubble-following cycles.
- start during busy: pulse start after the 4th transfer -> sequence continues at 0x201, and the counters do not clear.
- Reset mid-load: assert reset_n=0 after the 5th transfer -> outputs 0, state IDLE. A new start reloads from address 0.
- Restart from DONE: after a full load, start -> load_done=0 on the next cycle, weight_count=0, and the next write goes to address 0.
